// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the round-robin multiplier-sharing arbiter.
package mul_arb_pkg;

    localparam int MUL_ITERS = 32;

    typedef logic signed [31:0] Operand;
    typedef logic signed [63:0] Product;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } ArbState;

endpackage

// File: rtl/seq_booth_mul32.sv
// Sequential radix-2 Booth multiplier: one step per cycle, MUL_ITERS steps per product.
module seq_booth_mul32
    import mul_arb_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   start_i,
    input  Operand a_i,
    input  Operand b_i,
    output logic   done_o,
    output Product product_o
);

    localparam int ITER_W = $clog2(MUL_ITERS);

    logic [64:0]       acc_q, acc_d;
    Operand            mcand_q, mcand_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              run_q, run_d;
    logic [32:0]       mcandExt;
    logic [32:0]       partSum;

    // Partial sum is widened to 33 bits so that subtracting -2^31 cannot overflow.
    always_comb begin
        mcandExt = {mcand_q[31], mcand_q};
        partSum  = {acc_q[64], acc_q[64:33]};
        unique case (acc_q[1:0])
            2'b01:   partSum = {acc_q[64], acc_q[64:33]} + mcandExt;
            2'b10:   partSum = {acc_q[64], acc_q[64:33]} - mcandExt;
            default: partSum = {acc_q[64], acc_q[64:33]};
        endcase
    end

    always_comb begin
        acc_d   = acc_q;
        mcand_d = mcand_q;
        iter_d  = iter_q;
        run_d   = run_q;
        done_o  = 1'b0;
        if (start_i) begin
            acc_d   = {32'b0, b_i, 1'b0};
            mcand_d = a_i;
            iter_d  = '0;
            run_d   = 1'b1;
        end else if (run_q) begin
            acc_d  = {partSum, acc_q[32:1]};
            iter_d = iter_q + 1'b1;
            if (iter_q == ITER_W'(MUL_ITERS - 1)) begin
                run_d  = 1'b0;
                done_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q   <= '0;
            mcand_q <= '0;
            iter_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            iter_q  <= iter_d;
            run_q   <= run_d;
        end
    end

    assign product_o = acc_q[64:1];

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one sequential 32x32 signed multiplier among NUM_REQ requesters.
module mul_share_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [63:0]          resp_data,
    output logic [ID_W-1:0]      resp_id,
    output logic                 busy
);

    typedef logic [ID_W-1:0] ReqId;

    ArbState              state_q, state_d;
    ReqId                 rr_ptr_q, rr_ptr_d;
    ReqId                 id_q, id_d;
    logic [NUM_REQ-1:0]   grant;
    ReqId                 grantId;
    logic                 found;
    Operand               grantA, grantB;
    logic                 accept;
    logic                 mulDone;
    Product               mulProduct;
    int                   sum;
    ReqId                 idx;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant   = '0;
        grantId = rr_ptr_q;
        found   = 1'b0;
        grantA  = '0;
        grantB  = '0;
        sum     = 0;
        idx     = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            sum = int'(rr_ptr_q) + off;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            idx = ReqId'(sum);
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grantId    = idx;
                grantA     = req_a[{idx, 5'b0} +: 32];
                grantB     = req_b[{idx, 5'b0} +: 32];
            end
        end
    end

    assign accept    = (state_q == IDLE) && found && !RST;
    assign req_ready = accept ? grant : '0;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d  = BUSY;
                    id_d     = grantId;
                    rr_ptr_d = (grantId == ReqId'(NUM_REQ - 1)) ? '0 : grantId + 1'b1;
                end
            end
            BUSY: begin
                if (mulDone) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
        end
    end

    seq_booth_mul32 u_mul (
        .clk_i     (CLK),
        .rst_i     (RST),
        .start_i   (accept),
        .a_i       (grantA),
        .b_i       (grantB),
        .done_o    (mulDone),
        .product_o (mulProduct)
    );

    assign resp_valid = (state_q == DONE);
    assign resp_data  = mulProduct;
    assign resp_id    = id_q;
    assign busy       = (state_q != IDLE);

endmodule
